// File: rtl/megaram_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// megaram_mem_responder
//
// Memory-side responder for the MegaROM/SCC mapper. Each CPU bus cycle that
// targets the megaram window produces exactly one external-memory transaction.
// The Z80 is held in WAIT until memory acknowledges. A timeout aborts a hung
// transaction so that the bus can never freeze.
//
// Ports
//   clk_27m       in   system clock
//   reset         in   synchronous reset, active-high
//   megaram_req   in   mapper request, level, held for the whole bus cycle
//   megaram_wrt   in   request is a write (sampled only at start)
//   megaram_addr  in   21-bit mapped byte address
//   cpu_dout      in   CPU write data
//   mem_req       out  memory request, held until ack or timeout
//   mem_we        out  memory write enable, valid with mem_req
//   mem_addr      out  BASE_ADDR + megaram_addr, wrapping at 2^23
//   mem_wdata     out  memory write data
//   mem_ack       in   one-cycle completion pulse from memory
//   mem_rdata     in   read data, valid in the mem_ack cycle
//   bus_data      out  read data returned to the CPU
//   bus_data_en   out  drive bus_data onto the CPU bus
//   bus_wait_n    out  active-low Z80 WAIT
//   timeout_err   out  one-cycle pulse when a transaction aborts
// -----------------------------------------------------------------------------
module megaram_mem_responder #(
    parameter logic [22:0] BASE_ADDR = 23'h200000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_27m,
    input  logic        reset,
    input  logic        megaram_req,
    input  logic        megaram_wrt,
    input  logic [20:0] megaram_addr,
    input  logic [7:0]  cpu_dout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  bus_data,
    output logic        bus_data_en,
    output logic        bus_wait_n,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // r_cnt counts REQ cycles already completed, so the TIMEOUT-th REQ cycle
    // is the one where r_cnt holds TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_req_d;
    logic [7:0]  r_cnt;
    logic        r_is_read;
    logic        r_dropped;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [22:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [7:0]  r_bus_data;
    logic        r_bus_data_en;
    logic        r_bus_wait_n;
    logic        r_timeout_err;

    logic        w_start;
    logic        w_cnt_last;
    logic        w_abandon;
    logic [22:0] w_addr;

    // Start is the rising edge of megaram_req; req_d is tracked regardless of
    // state so a start landing on the DONE->IDLE cycle is still seen.
    assign w_start    = megaram_req & ~r_req_d;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // The CPU has left the bus cycle: finish the memory access quietly.
    assign w_abandon  = r_dropped | ~megaram_req;
    assign w_addr     = BASE_ADDR + {2'b00, megaram_addr};

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk_27m) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_d       <= 1'b0;
            r_cnt         <= 8'd0;
            r_is_read     <= 1'b0;
            r_dropped     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 23'd0;
            r_mem_wdata   <= 8'd0;
            r_bus_data    <= 8'hFF;
            r_bus_data_en <= 1'b0;
            r_bus_wait_n  <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_d       <= megaram_req;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_mem_we     <= megaram_wrt;
                        r_mem_addr   <= w_addr;
                        r_mem_wdata  <= cpu_dout;
                        r_is_read    <= ~megaram_wrt;
                        r_dropped    <= 1'b0;
                        r_cnt        <= 8'd0;
                        r_mem_req    <= 1'b1;
                        r_bus_wait_n <= 1'b0;
                        r_state      <= ST_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (!megaram_req) begin
                        r_dropped <= 1'b1;
                    end else begin
                        r_dropped <= r_dropped;
                    end
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_bus_wait_n <= 1'b1;
                        if (r_is_read && !w_abandon) begin
                            r_bus_data    <= mem_rdata;
                            r_bus_data_en <= 1'b1;
                        end else begin
                            r_bus_data_en <= 1'b0;
                        end
                        r_state <= w_abandon ? ST_IDLE : ST_DONE;
                    end else if (w_cnt_last) begin
                        r_mem_req     <= 1'b0;
                        r_bus_wait_n  <= 1'b1;
                        r_timeout_err <= 1'b1;
                        if (!w_abandon) begin
                            r_bus_data    <= 8'hFF;
                            r_bus_data_en <= r_is_read;
                        end else begin
                            r_bus_data_en <= 1'b0;
                        end
                        r_state <= w_abandon ? ST_IDLE : ST_DONE;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (!megaram_req) begin
                        r_bus_data_en <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_mem_req     <= 1'b0;
                    r_bus_wait_n  <= 1'b1;
                    r_bus_data_en <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign bus_data    = r_bus_data;
    assign bus_data_en = r_bus_data_en;
    assign bus_wait_n  = r_bus_wait_n;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_megaram_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_megaram_mem_responder
//
// Self-checking bench. Each transaction is described by its ack position
// (which REQ cycle carries mem_ack); the expected wait length, timeout pulse
// and returned data follow from that with plain arithmetic. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_megaram_mem_responder;

    localparam logic [22:0] BASE = 23'h200000;
    localparam int          TO   = 8;

    logic        clk_27m;
    logic        reset;
    logic        megaram_req;
    logic        megaram_wrt;
    logic [20:0] megaram_addr;
    logic [7:0]  cpu_dout;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  bus_data;
    logic        bus_data_en;
    logic        bus_wait_n;
    logic        timeout_err;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_bus_data;

    megaram_mem_responder #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clk_27m      (clk_27m),
        .reset        (reset),
        .megaram_req  (megaram_req),
        .megaram_wrt  (megaram_wrt),
        .megaram_addr (megaram_addr),
        .cpu_dout     (cpu_dout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .bus_data     (bus_data),
        .bus_data_en  (bus_data_en),
        .bus_wait_n   (bus_wait_n),
        .timeout_err  (timeout_err)
    );

    initial clk_27m = 1'b0;
    always #5 clk_27m = ~clk_27m;

    // Check every output against its reset value.
    task automatic test_reset(input string name);
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL %s mem_req: got %b expected 0", name, mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL %s mem_we: got %b expected 0", name, mem_we); end
        n_vec++; if (mem_addr !== 23'd0) begin n_err++; $display("FAIL %s mem_addr: got %h expected 0", name, mem_addr); end
        n_vec++; if (mem_wdata !== 8'd0) begin n_err++; $display("FAIL %s mem_wdata: got %h expected 0", name, mem_wdata); end
        n_vec++; if (bus_data !== 8'hFF) begin n_err++; $display("FAIL %s bus_data: got %h expected ff", name, bus_data); end
        n_vec++; if (bus_data_en !== 1'b0) begin n_err++; $display("FAIL %s bus_data_en: got %b expected 0", name, bus_data_en); end
        n_vec++; if (bus_wait_n !== 1'b1) begin n_err++; $display("FAIL %s bus_wait_n: got %b expected 1", name, bus_wait_n); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL %s timeout_err: got %b expected 0", name, timeout_err); end
    endtask

    // One full bus cycle: raise megaram_req, ack on REQ cycle ack_at (later
    // than TO means a late, ignored ack), hold the request for at least
    // 'hold' cycles, then drop it for one cycle. Called at a falling edge.
    task automatic run_txn(input bit wrt, input logic [20:0] addr, input logic [7:0] wd,
                           input int ack_at, input logic [7:0] rd, input int hold,
                           input string name);
        bit          ok;
        int          n;
        int          h;
        int          req_cnt;
        int          wait_cnt;
        int          err_cnt;
        int          rises;
        int          first_c;
        logic        prev_req;
        logic [22:0] exp_addr;
        ok       = (ack_at <= TO);
        n        = ok ? ack_at : TO;
        h        = ((n > ack_at) ? n : ack_at) + 2;
        if (hold > h) h = hold;
        exp_addr = BASE + {2'b00, addr};
        req_cnt  = 0; wait_cnt = 0; err_cnt = 0; rises = 0; first_c = -1;
        prev_req = mem_req;
        megaram_req  = 1'b1;
        megaram_wrt  = wrt;
        megaram_addr = addr;
        cpu_dout     = wd;
        mem_ack      = 1'b0;
        for (int c = 1; c <= h; c++) begin
            @(negedge clk_27m);
            if (mem_req === 1'b1) req_cnt++;
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                rises++;
                if (first_c < 0) first_c = c;
            end
            prev_req = mem_req;
            if (bus_wait_n === 1'b0) wait_cnt++;
            if (timeout_err === 1'b1) err_cnt++;
            if (c == n) begin
                n_vec++; if (mem_we !== wrt) begin n_err++; $display("FAIL %s mem_we: got %b expected %b", name, mem_we, wrt); end
                n_vec++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL %s mem_addr: got %h expected %h", name, mem_addr, exp_addr); end
                if (wrt) begin
                    n_vec++; if (mem_wdata !== wd) begin n_err++; $display("FAIL %s mem_wdata: got %h expected %h", name, mem_wdata, wd); end
                end
            end
            // Stimulus that must be ignored after the start.
            megaram_wrt  = 1'($urandom);
            cpu_dout     = 8'($urandom);
            megaram_addr = 21'($urandom);
            mem_ack      = (c == ack_at);
            mem_rdata    = (c == ack_at) ? rd : 8'($urandom);
        end
        if (ok && !wrt) exp_bus_data = rd;
        if (!ok) exp_bus_data = 8'hFF;
        n_vec++; if (rises !== 1) begin n_err++; $display("FAIL %s req_rises: got %0d expected 1", name, rises); end
        n_vec++; if (first_c !== 1) begin n_err++; $display("FAIL %s req_latency: got %0d expected 1", name, first_c); end
        n_vec++; if (req_cnt !== n) begin n_err++; $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cnt, n); end
        n_vec++; if (wait_cnt !== n) begin n_err++; $display("FAIL %s wait_cycles: got %0d expected %0d", name, wait_cnt, n); end
        n_vec++; if (err_cnt !== (ok ? 0 : 1)) begin n_err++; $display("FAIL %s timeout_pulses: got %0d expected %0d", name, err_cnt, ok ? 0 : 1); end
        n_vec++; if (bus_data_en !== !wrt) begin n_err++; $display("FAIL %s bus_data_en_held: got %b expected %b", name, bus_data_en, !wrt); end
        n_vec++; if (bus_data !== exp_bus_data) begin n_err++; $display("FAIL %s bus_data_held: got %h expected %h", name, bus_data, exp_bus_data); end
        n_vec++; if (mem_req !== 1'b0 || bus_wait_n !== 1'b1) begin n_err++; $display("FAIL %s released: got req=%b wait_n=%b expected req=0 wait_n=1", name, mem_req, bus_wait_n); end
        mem_ack     = 1'b0;
        megaram_req = 1'b0;
        @(negedge clk_27m);
        n_vec++; if (bus_data_en !== 1'b0) begin n_err++; $display("FAIL %s bus_data_en_drop: got %b expected 0", name, bus_data_en); end
        n_vec++; if (bus_data !== exp_bus_data) begin n_err++; $display("FAIL %s bus_data_retain: got %h expected %h", name, bus_data, exp_bus_data); end
    endtask

    task automatic test_read();
        run_txn(1'b0, 21'h04123, 8'h00, 6, 8'hA5, 0, "read_a5");
    endtask

    task automatic test_write();
        n_vec++; if (BASE + {2'b00, 21'h1FFFFF} !== 23'h3FFFFF) begin n_err++; $display("FAIL write_addr_model: got %h expected 3fffff", BASE + {2'b00, 21'h1FFFFF}); end
        run_txn(1'b1, 21'h1FFFFF, 8'h3C, 3, 8'h00, 0, "write_3c");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 21'h00010, 8'h00, TO + 3, 8'h5A, 0, "timeout_late_ack");
        run_txn(1'b1, 21'h00020, 8'h77, TO + 5, 8'h00, 0, "timeout_write");
    endtask

    task automatic test_ack_at_limit();
        run_txn(1'b0, 21'h0ABCD, 8'h00, TO, 8'h96, 0, "ack_at_timeout");
    endtask

    task automatic test_long_hold();
        run_txn(1'b0, 21'h12345, 8'h00, 4, 8'hC3, 40, "hold_40");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 21'h00001, 8'h00, 1, 8'h11, 0, "b2b_first");
        run_txn(1'b1, 21'h00002, 8'h22, 2, 8'h00, 0, "b2b_second");
        run_txn(1'b0, 21'h00003, 8'h00, 2, 8'h33, 0, "b2b_third");
    endtask

    // CPU leaves the bus cycle mid-transaction: memory still completes.
    task automatic test_abandon();
        int req_cnt;
        int en_cnt;
        req_cnt = 0; en_cnt = 0;
        megaram_req  = 1'b1;
        megaram_wrt  = 1'b0;
        megaram_addr = 21'h00100;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_27m);
            if (mem_req === 1'b1) req_cnt++;
            if (bus_data_en === 1'b1) en_cnt++;
            if (c == 2) megaram_req = 1'b0;
            mem_ack   = (c == 5);
            mem_rdata = 8'h4E;
        end
        mem_ack = 1'b0;
        n_vec++; if (req_cnt !== 5) begin n_err++; $display("FAIL abandon req_cycles: got %0d expected 5", req_cnt); end
        n_vec++; if (en_cnt !== 0) begin n_err++; $display("FAIL abandon bus_data_en_cycles: got %0d expected 0", en_cnt); end
        n_vec++; if (bus_wait_n !== 1'b1) begin n_err++; $display("FAIL abandon bus_wait_n: got %b expected 1", bus_wait_n); end
        run_txn(1'b0, 21'h00200, 8'h00, 3, 8'h6D, 0, "after_abandon");
    endtask

    // Reset two cycles into REQ, then a stray ack.
    task automatic test_reset_in_req();
        megaram_req  = 1'b1;
        megaram_wrt  = 1'b0;
        megaram_addr = 21'h0F0F0;
        for (int c = 1; c <= 2; c++) @(negedge clk_27m);
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_req_pre: got %b expected 1", mem_req); end
        reset       = 1'b1;
        megaram_req = 1'b0;
        @(negedge clk_27m);
        test_reset("reset_in_req");
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        @(negedge clk_27m);
        mem_ack = 1'b0;
        @(negedge clk_27m);
        exp_bus_data = 8'hFF;
        test_reset("stray_ack");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom), 21'($urandom), 8'($urandom), int'($urandom_range(1, TO + 3)),
                    8'($urandom), int'($urandom_range(0, 14)), "random");
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        exp_bus_data = 8'hFF;
        reset        = 1'b1;
        megaram_req  = 1'b0;
        megaram_wrt  = 1'b0;
        megaram_addr = 21'd0;
        cpu_dout     = 8'd0;
        mem_ack      = 1'b0;
        mem_rdata    = 8'd0;
        @(negedge clk_27m);
        @(negedge clk_27m);
        test_reset("reset");
        reset = 1'b0;
        @(negedge clk_27m);
        test_read();
        test_write();
        test_timeout();
        test_ack_at_limit();
        test_long_hold();
        test_back_to_back();
        test_abandon();
        test_reset_in_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
